// File: rtl/lsu_bus_master.sv
// Load/store initiator between the MEM stage and a word-organised req/ack data bus.
// Generates lane masks and replicated store data, extends load lanes, and reports faults and timeouts.
module lsu_bus_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [2:0]        mem_funct3,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              fault,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic access_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~a[0];
            3'b010:  ok = (a == 2'b00);
            3'b100:  ok = ~we;
            3'b101:  ok = ~we & ~a[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << a;
            2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{w[7:0]}};
            2'b01:   d = {2{w[15:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h000000, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0000, h};
            3'b010:  r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          lane_q, lane_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [3:0]          bus_be_q, bus_be_d;
    logic [31:0]         bus_wdata_q, bus_wdata_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic                bus_err_q, bus_err_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                legal_s;
    logic                timeout_s;

    // Request legality and timeout detection
    always_comb begin
        legal_s   = access_legal(mem_we, mem_funct3, mem_addr[1:0]);
        timeout_s = (TIMEOUT > 0) && (cnt_q == CNT_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack on the timeout cycle still completes normally
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    state_d = legal_s ? ST_BUS : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (bus_ack || timeout_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_BUS;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next-state; completion flags are single-cycle pulses
    always_comb begin
        we_d        = we_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    we_d        = mem_we;
                    f3_d        = mem_funct3;
                    lane_d      = mem_addr[1:0];
                    cnt_d       = {CNT_W{1'b0}};
                    bus_we_d    = mem_we;
                    bus_addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
                    bus_be_d    = lane_mask(mem_funct3, mem_addr[1:0]);
                    bus_wdata_d = mem_we ? lane_wdata(mem_funct3, mem_wdata) : 32'h0000_0000;
                    if (legal_s) begin
                        bus_req_d = 1'b1;
                    end else begin
                        bus_req_d = 1'b0;
                        done_d    = 1'b1;
                        fault_d   = 1'b1;
                        rdata_d   = 32'h0000_0000;
                    end
                end else begin
                    bus_req_d = 1'b0;
                end
            end
            ST_BUS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    rdata_d   = we_q ? 32'h0000_0000 : load_extract(f3_q, lane_q, bus_rdata);
                end else if (timeout_s) begin
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                    rdata_d   = 32'h0000_0000;
                end else begin
                    bus_req_d = 1'b1;
                end
            end
            ST_RESP: begin
                bus_req_d = 1'b0;
            end
            default: begin
                bus_req_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            lane_q      <= 2'b00;
            cnt_q       <= {CNT_W{1'b0}};
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= {ADDR_W{1'b0}};
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            rdata_q     <= 32'h0000_0000;
        end else begin
            we_q        <= we_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            bus_err_q   <= bus_err_d;
            rdata_q     <= rdata_d;
        end
    end

    // Pipeline hold: raised on the accept cycle and for every bus cycle
    always_comb begin
        stall = 1'b0;
        if (state_q == ST_BUS) begin
            stall = 1'b1;
        end else if ((state_q == ST_IDLE) && mem_req) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    assign done      = done_q;
    assign fault     = fault_q;
    assign bus_err   = bus_err_q;
    assign rdata     = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed cases with literal pins, then random
// transactions checked every cycle against a transaction-level model.
module tb_lsu_bus_master;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [2:0]  mem_funct3 = 3'b000;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic        stall, done, fault, bus_err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    always #5 clk = ~clk;

    lsu_bus_master #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall), .done(done), .rdata(rdata),
        .fault(fault), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    int n_checks = 0;
    int n_errs = 0;

    bit          chk_en = 1'b0;
    bit          e_stall, e_done, e_fault, e_err, e_breq, e_bf_en, e_bwe, e_rd_en;
    bit [31:0]   e_baddr, e_bwdata, e_rdata;
    bit [3:0]    e_be;
    bit [31:0]   last_rd = 32'h0;
    bit          rd_known = 1'b0;

    typedef struct packed {
        bit        en;
        bit        rd_en;
        bit        fault;
        bit        err;
        bit [3:0]  be;
        bit [31:0] baddr;
        bit [31:0] bwdata;
        bit [31:0] rd;
    } lit_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: access size in bytes is 2**funct3[1:0]; legal if the encoding exists and the address is size-aligned
    function automatic bit m_legal(input bit we, input bit [2:0] f3, input bit [31:0] a);
        int nb;
        int lane;
        nb = 1 << f3[1:0];
        lane = int'(a[1:0]);
        if (f3 == 3'd3 || f3 >= 3'd6) return 1'b0;
        if (we && f3[2]) return 1'b0;
        return (lane % nb) == 0;
    endfunction

    function automatic bit [3:0] m_be(input bit [2:0] f3, input bit [31:0] a);
        int nb;
        int lane;
        nb = 1 << f3[1:0];
        lane = int'(a[1:0]);
        return 4'(((1 << nb) - 1) << lane);
    endfunction

    function automatic bit [31:0] m_wdata(input bit [2:0] f3, input bit [31:0] w);
        if (f3[1:0] == 2'd0) return (w & 32'h0000_00FF) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return (w & 32'h0000_FFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] word);
        int nb;
        int lane;
        bit [31:0] mask;
        bit [31:0] v;
        nb = 1 << f3[1:0];
        lane = int'(a[1:0]);
        if (nb >= 4) return word;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v = (word >> (8 * lane)) & mask;
        if (!f3[2] && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic lit_t mk_lit(input bit rd_en, input bit flt, input bit err, input bit [3:0] be,
                                    input bit [31:0] baddr, input bit [31:0] bwdata, input bit [31:0] rd);
        lit_t l;
        l.en = 1'b1; l.rd_en = rd_en; l.fault = flt; l.err = err;
        l.be = be; l.baddr = baddr; l.bwdata = bwdata; l.rd = rd;
        return l;
    endfunction

    task automatic set_idle_exp();
        e_stall = 1'b0; e_done = 1'b0; e_fault = 1'b0; e_err = 1'b0;
        e_breq = 1'b0; e_bf_en = 1'b0; e_rd_en = rd_known; e_rdata = last_rd;
    endtask

    // Per-cycle compare against the model expectations
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(e_stall));
            chk("done", 32'(done), 32'(e_done));
            chk("fault", 32'(fault), 32'(e_fault));
            chk("bus_err", 32'(bus_err), 32'(e_err));
            chk("bus_req", 32'(bus_req), 32'(e_breq));
            if (e_bf_en) begin
                chk("bus_we", 32'(bus_we), 32'(e_bwe));
                chk("bus_addr", bus_addr, e_baddr);
                chk("bus_be", 32'(bus_be), 32'(e_be));
                chk("bus_wdata", bus_wdata, e_bwdata);
            end
            if (e_rd_en) chk("rdata", rdata, e_rdata);
        end
    end

    // One complete access; ack_at is the 1-based bus cycle that sees bus_ack (outside 1..TMO: never)
    task automatic run_txn(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd,
                           input int ack_at, input bit [31:0] ack_word, input lit_t lit);
        bit legal;
        bit err;
        int nbus;
        bit [31:0] exp_rd;
        legal = m_legal(we, f3, addr);
        err = legal && (ack_at < 1 || ack_at > TMO);
        nbus = !legal ? 0 : (err ? TMO : ack_at);

        mem_req = 1'b1; mem_we = we; mem_funct3 = f3; mem_addr = addr; mem_wdata = wd;
        bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
        set_idle_exp();
        e_stall = 1'b1;
        @(posedge clk); #1;

        for (int k = 1; k <= nbus; k++) begin
            bus_ack = (k == ack_at);
            bus_rdata = (k == ack_at) ? ack_word : $urandom;
            e_stall = 1'b1; e_breq = 1'b1; e_bf_en = 1'b1; e_bwe = we;
            e_baddr = addr & 32'hFFFF_FFFC;
            e_be = m_be(f3, addr);
            e_bwdata = we ? m_wdata(f3, wd) : 32'h0;
            if (lit.en && k == 1) begin
                @(negedge clk);
                chk("lit_bus_addr", bus_addr, lit.baddr);
                chk("lit_bus_be", 32'(bus_be), 32'(lit.be));
                chk("lit_bus_wdata", bus_wdata, lit.bwdata);
            end
            @(posedge clk); #1;
        end

        bus_ack = 1'($urandom_range(0, 1));
        e_stall = 1'b0; e_breq = 1'b0; e_bf_en = 1'b0;
        e_done = 1'b1; e_fault = !legal; e_err = err;
        if (legal) begin
            exp_rd = (err || we) ? 32'h0 : m_load(f3, addr, ack_word);
            last_rd = exp_rd; rd_known = 1'b1;
            e_rd_en = 1'b1; e_rdata = exp_rd;
        end else begin
            rd_known = 1'b0; e_rd_en = 1'b0;
        end
        if (lit.en) begin
            @(negedge clk);
            chk("lit_fault", 32'(fault), 32'(lit.fault));
            chk("lit_bus_err", 32'(bus_err), 32'(lit.err));
            if (lit.rd_en) chk("lit_rdata", rdata, lit.rd);
        end
        @(posedge clk); #1;
        mem_req = 1'b0;
        bus_ack = 1'($urandom_range(0, 1));
        set_idle_exp();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        lit_t no_lit;
        int   r;
        int   ack_at;
        no_lit = '0;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        last_rd = 32'h0; rd_known = 1'b1;
        set_idle_exp();
        chk_en = 1'b1;
        idle(1);

        run_txn(1'b1, 3'b000, 32'h13, 32'h1234_56A5, 1, 32'h0,
                mk_lit(1'b1, 1'b0, 1'b0, 4'b1000, 32'h10, 32'hA5A5_A5A5, 32'h0));
        run_txn(1'b0, 3'b000, 32'h101, 32'h0, 1, 32'h80FF_7F01,
                mk_lit(1'b1, 1'b0, 1'b0, 4'b0010, 32'h100, 32'h0, 32'h0000_007F));
        run_txn(1'b0, 3'b000, 32'h102, 32'h0, 1, 32'h80FF_7F01,
                mk_lit(1'b1, 1'b0, 1'b0, 4'b0100, 32'h100, 32'h0, 32'hFFFF_FFFF));
        run_txn(1'b0, 3'b100, 32'h102, 32'h0, 1, 32'h80FF_7F01,
                mk_lit(1'b1, 1'b0, 1'b0, 4'b0100, 32'h100, 32'h0, 32'h0000_00FF));
        run_txn(1'b0, 3'b001, 32'h202, 32'h0, 1, 32'h8001_0000,
                mk_lit(1'b1, 1'b0, 1'b0, 4'b1100, 32'h200, 32'h0, 32'hFFFF_8001));
        run_txn(1'b0, 3'b101, 32'h202, 32'h0, 1, 32'h8001_0000,
                mk_lit(1'b1, 1'b0, 1'b0, 4'b1100, 32'h200, 32'h0, 32'h0000_8001));
        run_txn(1'b0, 3'b010, 32'h302, 32'h0, 1, 32'h0,
                mk_lit(1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0));
        run_txn(1'b1, 3'b001, 32'h301, 32'h1111, 1, 32'h0,
                mk_lit(1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0));
        run_txn(1'b0, 3'b011, 32'h300, 32'h0, 1, 32'h0,
                mk_lit(1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0));
        idle(1);
        run_txn(1'b0, 3'b010, 32'h400, 32'h0, 5, 32'hCAFE_F00D,
                mk_lit(1'b1, 1'b0, 1'b0, 4'b1111, 32'h400, 32'h0, 32'hCAFE_F00D));
        run_txn(1'b0, 3'b010, 32'h500, 32'h0, 0, 32'h0,
                mk_lit(1'b1, 1'b0, 1'b1, 4'b1111, 32'h500, 32'h0, 32'h0));
        run_txn(1'b0, 3'b010, 32'h600, 32'h0, TMO, 32'h0BAD_C0DE,
                mk_lit(1'b1, 1'b0, 1'b0, 4'b1111, 32'h600, 32'h0, 32'h0BAD_C0DE));
        idle(1);

        // Reset in the middle of a bus transaction, then a stray ack
        chk_en = 1'b0;
        mem_req = 1'b1; mem_we = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h80; mem_wdata = 32'h55AA_55AA;
        bus_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pre_bus_req", 32'(bus_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; mem_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_bus_req", 32'(bus_req), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_bus_be", 32'(bus_be), 32'd0);
        chk("midrst_bus_addr", bus_addr, 32'd0);
        chk("midrst_bus_wdata", bus_wdata, 32'd0);
        chk("midrst_bus_we", 32'(bus_we), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b1;
        @(negedge clk);
        chk("late_ack_bus_req", 32'(bus_req), 32'd0);
        chk("late_ack_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        last_rd = 32'h0; rd_known = 1'b1;
        set_idle_exp();
        chk_en = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 1, 32'h0,
                mk_lit(1'b1, 1'b0, 1'b0, 4'b1111, 32'h40, 32'hDEAD_BEEF, 32'h0));

        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0) ack_at = 0;
            else if (r == 1) ack_at = TMO;
            else if (r == 2) ack_at = TMO + 1;
            else ack_at = $urandom_range(1, 6);
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                    ack_at, $urandom, no_lit);
            idle($urandom_range(0, 2));
        end

        idle(2);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
